mnist_image_loader: RTL and testbench
=====================================

// Module: mnist_image_loader
// PURPOSE
// - Upstream feeder for the ten per-class pseudo-linear learners: takes a serial 8-bit pixel stream plus a class label,
//   binarises each pixel, and assembles the 794-bit image_data word (784 pixel bits + 10-bit one-hot label).
// - Double-buffered: the next image fills while the current one is presented, so learners see back-to-back samples.
// - Drives all-zero image_data when idle; all-zero input gives result=0, y=0, error=0, so learners hold p unchanged.
// PARAMETERS
// - PIX_W        8    pixel width, bits
// - NUM_PIX      784  pixels per image (28x28)
// - NUM_CLASS    10   label classes; width of one-hot field
// - HOLD_CYCLES  1    consecutive cycles each image is presented (training steps per sample), >=1
// PORTS
// - clk          in   1            single clock, rising edge
// - rst          in   1            synchronous, active-high reset
// - bin_thresh   in   PIX_W        binarisation threshold; sampled with each accepted pixel
// - pix_valid    in   1            pixel beat valid
// - pix_ready    out  1            loader accepts pixel beat
// - pix_data     in   PIX_W        pixel value, raster order, pixel 0 first
// - pix_last     in   1            marks final pixel of image
// - label_valid  in   1            label valid
// - label_ready  out  1            loader accepts label
// - label        in   4            class index 0..9
// - image_data   out  NUM_PIX+10   [793:10] pixel bits (pixel m at bit m+10), [9:0] one-hot label (class k -> bit k)
// - image_valid  out  1            image_data holds a live sample this cycle
// - sample_count out  16           images issued to output since reset
// - frame_err    out  1            sticky: pix_last position wrong
// - label_err    out  1            sticky: label >= NUM_CLASS received
// BEHAVIOUR
// - Reset: image_data=0, image_valid=0, pix_ready=0, label_ready=0, sample_count=0, frame_err=0, label_err=0;
//   FSM -> FILL, pixel index=0, shadow cleared; partial frame discarded (reset mid-frame or mid-presentation).
// - Input FSM (shadow side): FILL -> WAIT_LABEL -> WAIT_SWAP -> FILL.
//   FILL: pix_ready=1. Beat accepted when pix_valid&pix_ready; shadow bit[idx] = (pix_data >= bin_thresh); idx++.
//   Accept at idx=NUM_PIX-1 -> WAIT_LABEL; if pix_last=0 there, set frame_err.
//   pix_last=1 at idx<NUM_PIX-1 -> set frame_err, remaining bits 0, -> WAIT_LABEL.
//   WAIT_LABEL: label_ready=1; on label_valid: one-hot(label) stored; label>=10 -> label field 0, label_err set. -> WAIT_SWAP.
//   WAIT_SWAP: swap when output side free this cycle (see below); shadow -> output register, idx=0, -> FILL.
// - Output side: hold counter 0..HOLD_CYCLES-1. On swap: image_valid=1 next cycle, counter=0, sample_count++ (wraps FFFF->0).
//   image_data stable for exactly HOLD_CYCLES cycles while image_valid=1.
//   Output free = image_valid=0, or image_valid=1 with counter==HOLD_CYCLES-1 (back-to-back, no gap cycle).
//   At end of hold with no swap: image_valid=0 and image_data=0 next cycle.
// - Latency: label accepted in cycle T with output free in T+1 -> swap in T+1, image_valid=1 in T+2.
// - Max throughput: one image per max(NUM_PIX+1 input beats, HOLD_CYCLES) cycles plus WAIT_SWAP stalls.
// - bin_thresh changes mid-frame apply only to subsequent beats. Sticky errors cleared only by rst.
// STRUCTURE
// - Shared package mnist_pkg: NUM_PIX, NUM_CLASS, IMG_W=794, PIX_LSB=10, LABEL_LSB=0, loader state enum.
// - Sub-module mnist_label_onehot: 4-bit label -> 10-bit one-hot + out-of-range flag (combinational).
// - Top holds FSM, 10-bit pixel index, shadow/output 794-bit registers, hold counter, sample counter.
// TESTING
// - Reset then 784 beats all 0xFF, pix_last on beat 784, bin_thresh=0x80, label=2, output idle -> image_valid 1 cycle,
//   image_data = {784{1'b1}, 10'b0000000100}, sample_count=1, frame_err=0.
// - Pixels alternating 0x7F/0x80 with bin_thresh=0x80 -> pixel bits alternate 0/1 starting at bit 10=0; bit 11=1.
// - HOLD_CYCLES=4, two images streamed with no input stalls -> image_valid high 4 cycles each, continuous if second ready;
//   image_data switches exactly on cycle 5; otherwise image_data=0 between samples.
// - pix_last on beat 100 -> frame_err=1, bits [793:110]=0; label=9 -> image_data[9]=1; next frame loads normally.
// - label=12 -> label_err=1, image_data[9:0]=0; rst asserted mid-fill -> all outputs 0, next frame starts at pixel 0.
// - sample_count preset path: issue 65536 images (HOLD_CYCLES=1, short test NUM_PIX=4) -> count wraps to 0.

Source files
------------

// File: rtl/mnist_pkg.sv
// Shared constants and the loader state type for the MNIST image feeder.
package mnist_pkg;

    localparam int NUM_PIX   = 784;               // 28x28 pixels per image
    localparam int NUM_CLASS = 10;                // label classes, one-hot width
    localparam int LABEL_W   = 4;                 // class index width
    localparam int IMG_W     = NUM_PIX + NUM_CLASS;
    localparam int PIX_LSB   = 10;                // pixel m lands at image bit m+PIX_LSB
    localparam int LABEL_LSB = 0;                 // one-hot label occupies the low bits
    localparam int COUNT_W   = 16;                // sample counter width

    // Shadow-side fill sequence.
    typedef enum logic [1:0] {
        ST_FILL       = 2'd0,
        ST_WAIT_LABEL = 2'd1,
        ST_WAIT_SWAP  = 2'd2
    } loader_state_t;

endpackage

// File: rtl/mnist_image_loader_if.sv
// Pixel and label input channels of the image loader.
// Handshake: a beat transfers on a rising clk edge where valid and ready are
// both high; the source holds valid and its payload stable until that edge,
// and ready never depends combinationally on valid.
interface mnist_image_loader_if #(
    parameter int PIX_W = 8
);
    logic [PIX_W-1:0] bin_thresh;
    logic             pix_valid;
    logic             pix_ready;
    logic [PIX_W-1:0] pix_data;
    logic             pix_last;
    logic             label_valid;
    logic             label_ready;
    logic [3:0]       label;

    modport master (
        output bin_thresh, pix_valid, pix_data, pix_last, label_valid, label,
        input  pix_ready, label_ready
    );

    modport slave (
        input  bin_thresh, pix_valid, pix_data, pix_last, label_valid, label,
        output pix_ready, label_ready
    );
endinterface

// File: rtl/mnist_label_onehot.sv
// Class index to one-hot label field; indices past the last class give all-zero.
module mnist_label_onehot
    import mnist_pkg::*;
(
    input  logic [LABEL_W-1:0]   label,
    output logic [NUM_CLASS-1:0] onehot,
    output logic                 out_of_range
);

    // Decode the index, suppressing the field when it names no class.
    always_comb begin
        onehot       = '0;
        out_of_range = (label >= LABEL_W'(NUM_CLASS));
        if (!out_of_range) begin
            onehot[label] = 1'b1;
        end
    end

endmodule

// File: rtl/mnist_image_loader.sv
// Serial pixel/label stream to double-buffered image word for the per-class
// learners. The shadow register fills while the output register is presented.
module mnist_image_loader
    import mnist_pkg::*;
#(
    parameter int                 PIX_W        = 8,
    parameter int                 NUM_PIX      = mnist_pkg::NUM_PIX,
    parameter int                 HOLD_CYCLES  = 1,
    // Reset value of sample_count; non-zero only for bring-up of the wrap path.
    parameter logic [COUNT_W-1:0] COUNT_PRESET = '0
) (
    input  logic                          clk,
    input  logic                          rst,
    mnist_image_loader_if.slave           in_if,
    output logic [NUM_PIX+NUM_CLASS-1:0]  image_data,
    output logic                          image_valid,
    output logic [COUNT_W-1:0]            sample_count,
    output logic                          frame_err,
    output logic                          label_err,
    output loader_state_t                 dbg_state
);

    localparam int IMG_BITS = NUM_PIX + NUM_CLASS;
    localparam int IDX_W    = (NUM_PIX > 1) ? $clog2(NUM_PIX) : 1;
    localparam int HOLD_W   = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
    localparam int SEL_W    = $clog2(IMG_BITS);
    localparam logic [IDX_W-1:0]  LAST_IDX  = IDX_W'(NUM_PIX - 1);
    localparam logic [HOLD_W-1:0] LAST_HOLD = HOLD_W'(HOLD_CYCLES - 1);

    loader_state_t         state_q, state_d;
    logic [IDX_W-1:0]      idx_q;
    logic [IMG_BITS-1:0]   shadow_q;
    logic [IMG_BITS-1:0]   out_q;
    logic                  valid_q;
    logic [HOLD_W-1:0]     hold_q;
    logic [COUNT_W-1:0]    count_q;
    logic                  ferr_q, lerr_q;

    logic                  pix_ready_c, label_ready_c;
    logic                  pix_fire, label_fire, out_free, swap;
    logic                  pix_bit, at_last_idx;
    logic [SEL_W-1:0]      wr_sel;
    logic [NUM_CLASS-1:0]  lab_onehot;
    logic                  lab_bad;

    mnist_label_onehot u_onehot (
        .label        (in_if.label),
        .onehot       (lab_onehot),
        .out_of_range (lab_bad)
    );

    // Transfers are qualified from state directly so ready stays loop-free.
    assign pix_fire    = in_if.pix_valid & (state_q == ST_FILL) & ~rst;
    assign label_fire  = in_if.label_valid & (state_q == ST_WAIT_LABEL) & ~rst;
    // The output register may be overwritten when idle or on its final hold cycle.
    assign out_free    = ~valid_q | (hold_q == LAST_HOLD);
    assign swap        = (state_q == ST_WAIT_SWAP) & out_free;
    assign pix_bit     = (in_if.pix_data >= in_if.bin_thresh);
    assign at_last_idx = (idx_q == LAST_IDX);
    assign wr_sel      = SEL_W'(PIX_LSB) + SEL_W'(idx_q);

    // Next-state and ready decode for the shadow-side fill sequence.
    always_comb begin
        state_d       = state_q;
        pix_ready_c   = 1'b0;
        label_ready_c = 1'b0;
        case (state_q)
            ST_FILL: begin
                pix_ready_c = ~rst;
                if (pix_fire && (at_last_idx || in_if.pix_last)) begin
                    state_d = ST_WAIT_LABEL;
                end
            end
            ST_WAIT_LABEL: begin
                label_ready_c = ~rst;
                if (label_fire) begin
                    state_d = ST_WAIT_SWAP;
                end
            end
            ST_WAIT_SWAP: begin
                if (out_free) begin
                    state_d = ST_FILL;
                end
            end
            default: state_d = ST_FILL;
        endcase
    end

    // Shadow side: state, pixel index, binarised bits, label field, sticky errors.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_FILL;
            idx_q    <= '0;
            shadow_q <= '0;
            ferr_q   <= 1'b0;
            lerr_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            if (pix_fire) begin
                shadow_q[wr_sel] <= pix_bit;
                idx_q            <= idx_q + 1'b1;
                // Last flag must coincide exactly with the final pixel position.
                if (at_last_idx != in_if.pix_last) begin
                    ferr_q <= 1'b1;
                end
            end
            if (label_fire) begin
                shadow_q[LABEL_LSB +: NUM_CLASS] <= lab_onehot;
                if (lab_bad) begin
                    lerr_q <= 1'b1;
                end
            end
            // Cleared on hand-off so a short frame leaves its tail bits at zero.
            if (swap) begin
                shadow_q <= '0;
                idx_q    <= '0;
            end
        end
    end

    // Output side: load on swap, hold for HOLD_CYCLES, then blank to zero.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_q   <= '0;
            valid_q <= 1'b0;
            hold_q  <= '0;
            count_q <= COUNT_PRESET;
        end else if (swap) begin
            out_q   <= shadow_q;
            valid_q <= 1'b1;
            hold_q  <= '0;
            count_q <= count_q + 1'b1;
        end else if (valid_q) begin
            if (hold_q == LAST_HOLD) begin
                out_q   <= '0;
                valid_q <= 1'b0;
                hold_q  <= '0;
            end else begin
                hold_q <= hold_q + 1'b1;
            end
        end
    end

    assign in_if.pix_ready   = pix_ready_c;
    assign in_if.label_ready = label_ready_c;
    assign image_data        = out_q;
    assign image_valid       = valid_q;
    assign sample_count      = count_q;
    assign frame_err         = ferr_q;
    assign label_err         = lerr_q;
    assign dbg_state         = state_q;

endmodule

// File: tb/tb_mnist_image_loader.sv
// Directed bench: a full-size loader (784 pixels, hold 1) and a small loader
// (2 pixels, hold 4, counter preset near wrap) share one clock and reset.
module tb_mnist_image_loader;
    import mnist_pkg::*;

    localparam int AW = IMG_W;
    localparam int BN = 2;
    localparam int BW = BN + NUM_CLASS;
    localparam int TW = 1 + COUNT_W + BW;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    mnist_image_loader_if a_if ();
    mnist_image_loader_if b_if ();

    logic [AW-1:0]      a_data;
    logic               a_valid, a_ferr, a_lerr;
    logic [COUNT_W-1:0] a_count;
    loader_state_t      a_state;
    logic [BW-1:0]      b_data;
    logic               b_valid, b_ferr, b_lerr;
    logic [COUNT_W-1:0] b_count;
    loader_state_t      b_state;

    mnist_image_loader #(.PIX_W(8), .NUM_PIX(NUM_PIX), .HOLD_CYCLES(1)) dut_a (
        .clk(clk), .rst(rst), .in_if(a_if),
        .image_data(a_data), .image_valid(a_valid), .sample_count(a_count),
        .frame_err(a_ferr), .label_err(a_lerr), .dbg_state(a_state)
    );

    mnist_image_loader #(.PIX_W(8), .NUM_PIX(BN), .HOLD_CYCLES(4),
                         .COUNT_PRESET(16'hFFFE)) dut_b (
        .clk(clk), .rst(rst), .in_if(b_if),
        .image_data(b_data), .image_valid(b_valid), .sample_count(b_count),
        .frame_err(b_ferr), .label_err(b_lerr), .dbg_state(b_state)
    );

    // ---------------- scoreboard ----------------
    int checks = 0;
    int errors = 0;
    logic [TW-1:0] exp_q[$];
    logic [TW-1:0] trace_q[$];
    bit rec_en = 1'b0;

    always @(negedge clk) begin
        if (rec_en) trace_q.push_back({b_valid, b_count, b_data});
    end

    task automatic check(input string tag, input logic [AW-1:0] got, input logic [AW-1:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic timeout(input string tag);
        checks++;
        errors++;
        $error("FAIL %s got=timeout exp=handshake", tag);
    endtask

    // ---------------- driver tasks ----------------
    task automatic put_pix(input bit b, input logic [7:0] d, input logic last, input logic [7:0] th);
        int w = 0;
        if (b) begin
            b_if.pix_valid = 1'b1; b_if.pix_data = d; b_if.pix_last = last; b_if.bin_thresh = th;
        end else begin
            a_if.pix_valid = 1'b1; a_if.pix_data = d; a_if.pix_last = last; a_if.bin_thresh = th;
        end
        while (!(b ? b_if.pix_ready : a_if.pix_ready) && w < 20) begin
            @(negedge clk);
            w++;
        end
        if (w >= 20) timeout("pix_ready_wait");
        @(negedge clk);
    endtask

    task automatic put_label(input bit b, input logic [3:0] lab);
        int w = 0;
        if (b) begin
            b_if.pix_valid = 1'b0; b_if.pix_last = 1'b0; b_if.label_valid = 1'b1; b_if.label = lab;
        end else begin
            a_if.pix_valid = 1'b0; a_if.pix_last = 1'b0; a_if.label_valid = 1'b1; a_if.label = lab;
        end
        while (!(b ? b_if.label_ready : a_if.label_ready) && w < 20) begin
            @(negedge clk);
            w++;
        end
        if (w >= 20) timeout("label_ready_wait");
        @(negedge clk);
        if (b) b_if.label_valid = 1'b0;
        else   a_if.label_valid = 1'b0;
    endtask

    // mode 0: all 0xFF; 1: 0x7F/0x80 alternating; 2: 0xFF/0x00; 3: 0x00/0xFF
    task automatic send_frame(input bit b, input int n, input int mode, input int last_at,
                              input logic [3:0] lab, input logic [7:0] th);
        for (int i = 0; i < n; i++) begin
            logic [7:0] d;
            case (mode)
                0:       d = 8'hFF;
                1:       d = i[0] ? 8'h80 : 8'h7F;
                2:       d = i[0] ? 8'h00 : 8'hFF;
                default: d = i[0] ? 8'hFF : 8'h00;
            endcase
            put_pix(b, d, (i == last_at), th);
            if (i == last_at) break;
        end
        put_label(b, lab);
    endtask

    // Called on the falling edge right after the label transfer.
    task automatic present_a(input string tag, input logic [AW-1:0] exp_data,
                             input logic [COUNT_W-1:0] exp_cnt, input logic exp_ferr, input logic exp_lerr);
        check({tag, "_state_wait_swap"}, a_state, ST_WAIT_SWAP);
        check({tag, "_valid_before"}, a_valid, 1'b0);
        @(negedge clk);
        check({tag, "_valid"}, a_valid, 1'b1);
        check({tag, "_data"}, a_data, exp_data);
        check({tag, "_count"}, a_count, exp_cnt);
        check({tag, "_frame_err"}, a_ferr, exp_ferr);
        check({tag, "_label_err"}, a_lerr, exp_lerr);
        @(negedge clk);
        check({tag, "_valid_after"}, a_valid, 1'b0);
        check({tag, "_data_after"}, a_data, '0);
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        logic [TW-1:0] got;
        a_if.bin_thresh = 8'h80; a_if.pix_valid = 1'b0; a_if.pix_data = '0; a_if.pix_last = 1'b0;
        a_if.label_valid = 1'b0; a_if.label = '0;
        b_if.bin_thresh = 8'h80; b_if.pix_valid = 1'b0; b_if.pix_data = '0; b_if.pix_last = 1'b0;
        b_if.label_valid = 1'b0; b_if.label = '0;
        rst = 1'b1;
        repeat (2) @(negedge clk);

        check("rst_valid", a_valid, 1'b0);
        check("rst_data", a_data, '0);
        check("rst_count", a_count, 16'h0000);
        check("rst_ferr", a_ferr, 1'b0);
        check("rst_lerr", a_lerr, 1'b0);
        check("rst_pix_ready", a_if.pix_ready, 1'b0);
        check("rst_label_ready", a_if.label_ready, 1'b0);
        check("rst_b_count_preset", b_count, 16'hFFFE);
        check("rst_b_valid", b_valid, 1'b0);

        rst = 1'b0;
        @(negedge clk);
        check("fill_pix_ready", a_if.pix_ready, 1'b1);
        check("fill_state", a_state, ST_FILL);

        // All-white image, class 2.
        send_frame(1'b0, NUM_PIX, 0, NUM_PIX - 1, 4'd2, 8'h80);
        present_a("white", {{784{1'b1}}, 10'b0000000100}, 16'd1, 1'b0, 1'b0);

        // Threshold boundary: 0x7F -> 0, 0x80 -> 1, pixel 0 first; class 0.
        send_frame(1'b0, NUM_PIX, 1, NUM_PIX - 1, 4'd0, 8'h80);
        present_a("alt", {{392{2'b10}}, 10'b0000000001}, 16'd2, 1'b0, 1'b0);

        // Early last on beat 100 (pixel 99); class 9.
        send_frame(1'b0, NUM_PIX, 0, 99, 4'd9, 8'h80);
        present_a("short", {{684{1'b0}}, {100{1'b1}}, 10'b1000000000}, 16'd3, 1'b1, 1'b0);

        // Full frame after the short one, out-of-range class 12.
        send_frame(1'b0, NUM_PIX, 0, NUM_PIX - 1, 4'd12, 8'h80);
        present_a("badlabel", {{784{1'b1}}, 10'b0000000000}, 16'd4, 1'b1, 1'b1);

        // Reset mid-fill discards the partial frame and clears sticky errors.
        for (int i = 0; i < 50; i++) put_pix(1'b0, 8'hFF, 1'b0, 8'h80);
        a_if.pix_valid = 1'b0;
        rst = 1'b1;
        repeat (2) @(negedge clk);
        check("midrst_valid", a_valid, 1'b0);
        check("midrst_data", a_data, '0);
        check("midrst_count", a_count, 16'h0000);
        check("midrst_ferr", a_ferr, 1'b0);
        check("midrst_lerr", a_lerr, 1'b0);
        check("midrst_pix_ready", a_if.pix_ready, 1'b0);
        rst = 1'b0;
        @(negedge clk);
        send_frame(1'b0, NUM_PIX, 1, NUM_PIX - 1, 4'd5, 8'h80);
        present_a("after_rst", {{392{2'b10}}, 10'b0000100000}, 16'd1, 1'b0, 1'b0);

        // Small loader: two back-to-back images, hold 4, counter wraps FFFF -> 0.
        rec_en = 1'b1;
        send_frame(1'b1, BN, 2, BN - 1, 4'd3, 8'h80);
        send_frame(1'b1, BN, 3, BN - 1, 4'd7, 8'h80);
        repeat (8) @(negedge clk);
        rec_en = 1'b0;

        repeat (4) exp_q.push_back({1'b1, 16'hFFFF, 12'h408});
        repeat (4) exp_q.push_back({1'b1, 16'h0000, 12'h880});
        repeat (2) exp_q.push_back({1'b0, 16'h0000, 12'h000});

        while (trace_q.size() > 0 && trace_q[0][TW-1] == 1'b0) void'(trace_q.pop_front());
        while (exp_q.size() > 0) begin
            got = (trace_q.size() > 0) ? trace_q.pop_front() : 'x;
            check("b_seq", got, exp_q.pop_front());
        end
        check("b_ferr", b_ferr, 1'b0);
        check("b_lerr", b_lerr, 1'b0);
        check("b_final_count", b_count, 16'h0000);

        // ---------------- report ----------------
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
